// File: rtl/asca_pkg.sv
// asca_pkg: shared defaults and stack-op encoding for the asca register file.
// Imported by asca_stack_ctl and asca_regfile.
package asca_pkg;

  localparam int          DATA_W_DEF      = 16;
  localparam int          REG_N_DEF       = 4;
  localparam int unsigned STACK_TOP_DEF   = 32'h0000_FFFF;
  localparam int unsigned STACK_DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_ILLEGAL = 2'd3
  } stk_op_e;

  function automatic stk_op_e stk_op_decode(
    input logic push,
    input logic pop
  );
    stk_op_e op;
    op = OP_IDLE;
    unique case (1'b1)
      (push &  pop): op = OP_ILLEGAL;
      (push & ~pop): op = OP_PUSH;
      (~push & pop): op = OP_POP;
      default:       op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/asca_stack_ctl.sv
// asca_stack_ctl: full-descending stack pointer, entry count,
// sticky error flags and the memory address mux.
module asca_stack_ctl
  import asca_pkg::*;
#(
  parameter int          DATA_W      = DATA_W_DEF,
  parameter int unsigned STACK_TOP   = STACK_TOP_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] ptr_i,
  output logic [DATA_W-1:0] stk_addr,
  output logic [DATA_W-1:0] sp,
  output logic [DATA_W-1:0] stk_cnt,
  output logic              stk_ovf,
  output logic              stk_unf,
  output logic              stk_err
);

  localparam logic [DATA_W-1:0] TOP_V   = DATA_W'(STACK_TOP);
  localparam logic [DATA_W-1:0] DEPTH_V = DATA_W'(STACK_DEPTH);
  localparam logic [DATA_W-1:0] ONE_V   = DATA_W'(1);

  stk_op_e op;

  logic [DATA_W-1:0] sp_d,  sp_q;
  logic [DATA_W-1:0] cnt_d, cnt_q;
  logic              ovf_d, ovf_q;
  logic              unf_d, unf_q;
  logic              err_d, err_q;
  logic [DATA_W-1:0] sp_inc;
  logic [DATA_W-1:0] sp_dec;

  assign op     = stk_op_decode(push, pop);
  assign sp_inc = sp_q + ONE_V;
  assign sp_dec = sp_q - ONE_V;

  // Clear first, then let any error event this cycle re-set its flag.
  always_comb begin
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q & ~err_clr;
    unf_d    = unf_q & ~err_clr;
    err_d    = err_q & ~err_clr;
    stk_addr = ptr_i;
    unique case (op)
      OP_PUSH: begin
        stk_addr = sp_q;
        if (cnt_q == DEPTH_V) begin
          ovf_d = 1'b1;
        end else begin
          sp_d  = sp_dec;
          cnt_d = cnt_q + ONE_V;
        end
      end
      OP_POP: begin
        stk_addr = sp_inc;
        if (cnt_q == '0) begin
          unf_d = 1'b1;
        end else begin
          sp_d  = sp_inc;
          cnt_d = cnt_q - ONE_V;
        end
      end
      OP_ILLEGAL: begin
        stk_addr = sp_q;
        err_d    = 1'b1;
      end
      OP_IDLE: begin
        stk_addr = ptr_i;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= TOP_V;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      err_q <= err_d;
    end
  end

  assign sp      = sp_q;
  assign stk_cnt = cnt_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;
  assign stk_err = err_q;

endmodule

// File: rtl/asca_regfile.sv
// asca_regfile: 2-read/1-write register file with a hardware stack pointer.
// Define ASCA_RF_BYPASS_EN to forward same-cycle writes to the read ports.
module asca_regfile
  import asca_pkg::*;
#(
  parameter int          DATA_W      = DATA_W_DEF,
  parameter int          REG_N       = REG_N_DEF,
  parameter int unsigned STACK_TOP   = STACK_TOP_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_N-1:0]  rd_a_idx,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [REG_N-1:0]  rd_b_idx,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wr_en,
  input  logic [REG_N-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] stk_addr,
  output logic [DATA_W-1:0] sp,
  output logic [DATA_W-1:0] stk_cnt,
  output logic              stk_ovf,
  output logic              stk_unf,
  output logic              stk_err,
  input  logic              err_clr
);

  localparam int NREGS = 2 ** REG_N;

  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] regs_q [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_a_data = regs_q[rd_a_idx];
    rd_b_data = regs_q[rd_b_idx];
`ifdef ASCA_RF_BYPASS_EN
    if (wr_en && (wr_idx == rd_a_idx)) begin
      rd_a_data = wr_data;
    end
    if (wr_en && (wr_idx == rd_b_idx)) begin
      rd_b_data = wr_data;
    end
`else
`endif
  end

  // Port B doubles as the memory pointer when the stack is idle.
  asca_stack_ctl #(
    .DATA_W      (DATA_W),
    .STACK_TOP   (STACK_TOP),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack_ctl (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .err_clr  (err_clr),
    .ptr_i    (rd_b_data),
    .stk_addr (stk_addr),
    .sp       (sp),
    .stk_cnt  (stk_cnt),
    .stk_ovf  (stk_ovf),
    .stk_unf  (stk_unf),
    .stk_err  (stk_err)
  );

endmodule

// File: tb/tb_asca_regfile.sv
// tb_asca_regfile: directed stimulus with a queued scoreboard.
// Two instances share inputs: default depth and depth 2.
module tb_asca_regfile;

  localparam int DW = 16;
  localparam int RN = 4;

  localparam int S_A    = 0;
  localparam int S_B    = 1;
  localparam int S_ADDR = 2;
  localparam int S_SP   = 3;
  localparam int S_CNT  = 4;
  localparam int S_OVF  = 5;
  localparam int S_UNF  = 6;
  localparam int S_ERR  = 7;

`ifdef ASCA_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [RN-1:0] rd_a_idx, rd_b_idx, wr_idx;
  logic          wr_en, push, pop, err_clr;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] a1, b1, addr1, sp1, cnt1;
  logic          ovf1, unf1, err1;
  logic [DW-1:0] a2, b2, addr2, sp2, cnt2;
  logic          ovf2, unf2, err2;

  always #5 clk = ~clk;

  asca_regfile u_dut (
    .clk(clk), .reset(reset),
    .rd_a_idx(rd_a_idx), .rd_a_data(a1),
    .rd_b_idx(rd_b_idx), .rd_b_data(b1),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .push(push), .pop(pop),
    .stk_addr(addr1), .sp(sp1), .stk_cnt(cnt1),
    .stk_ovf(ovf1), .stk_unf(unf1), .stk_err(err1),
    .err_clr(err_clr)
  );

  asca_regfile #(.STACK_DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .rd_a_idx(rd_a_idx), .rd_a_data(a2),
    .rd_b_idx(rd_b_idx), .rd_b_data(b2),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .push(push), .pop(pop),
    .stk_addr(addr2), .sp(sp2), .stk_cnt(cnt2),
    .stk_ovf(ovf2), .stk_unf(unf2), .stk_err(err2),
    .err_clr(err_clr)
  );

  typedef struct {
    int            cyc;
    int            u;
    int            s;
    logic [DW-1:0] v;
    string         nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] act(input int u, input int s);
    logic [DW-1:0] r;
    r = '0;
    case (s)
      S_A:    r = (u == 1) ? a1 : a2;
      S_B:    r = (u == 1) ? b1 : b2;
      S_ADDR: r = (u == 1) ? addr1 : addr2;
      S_SP:   r = (u == 1) ? sp1 : sp2;
      S_CNT:  r = (u == 1) ? cnt1 : cnt2;
      S_OVF:  r = DW'((u == 1) ? ovf1 : ovf2);
      S_UNF:  r = DW'((u == 1) ? unf1 : unf2);
      S_ERR:  r = DW'((u == 1) ? err1 : err2);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input int u, input int s,
                     input logic [DW-1:0] v, input string nm);
    exp_t e;
    e.cyc = cyc;
    e.u   = u;
    e.s   = s;
    e.v   = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // Monitor: compares every expectation due in the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          n_chk++;
          if (act(sb[i].u, sb[i].s) !== sb[i].v) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h",
                     sb[i].nm, sb[i].u, act(sb[i].u, sb[i].s), sb[i].v);
          end
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s dut%0d: not sampled", sb[i].nm, sb[i].u);
          sb.delete(i);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    rd_a_idx = '0;
    rd_b_idx = '0;
    wr_idx   = '0;
    wr_en    = 1'b0;
    wr_data  = '0;
    push     = 1'b0;
    pop      = 1'b0;
    err_clr  = 1'b0;
    step();
    step();
    reset = 1'b0;

    chk(1, S_SP, 16'hFFFF, "rst_sp");
    chk(2, S_SP, 16'hFFFF, "rst_sp");
    chk(1, S_CNT, 16'h0, "rst_cnt");
    chk(1, S_OVF, 16'h0, "rst_ovf");
    chk(1, S_UNF, 16'h0, "rst_unf");
    chk(1, S_ERR, 16'h0, "rst_err");
    chk(1, S_A, 16'h0, "rst_r0");
    chk(1, S_ADDR, 16'h0, "rst_idle_addr");

    wr_en    = 1'b1;
    wr_idx   = 4'd3;
    wr_data  = 16'h1234;
    rd_a_idx = 4'd3;
    rd_b_idx = 4'd3;
    chk(1, S_A, BYP ? 16'h1234 : 16'h0000, "same_cyc_a");
    chk(1, S_B, BYP ? 16'h1234 : 16'h0000, "same_cyc_b");
    step();
    wr_en = 1'b0;
    chk(1, S_A, 16'h1234, "next_cyc_a");
    chk(1, S_B, 16'h1234, "next_cyc_b");
    chk(1, S_ADDR, 16'h1234, "idle_addr_b");
    step();
    wr_en    = 1'b1;
    wr_idx   = 4'd5;
    wr_data  = 16'hBEEF;
    rd_a_idx = 4'd5;
    chk(1, S_A, BYP ? 16'hBEEF : 16'h0000, "r5_same_cyc");
    chk(1, S_B, 16'h1234, "r3_other_port");
    step();
    wr_en = 1'b0;
    chk(1, S_A, 16'hBEEF, "r5_next_cyc");
    step();

    rd_a_idx = 4'd0;
    rd_b_idx = 4'd0;
    push     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en   = (i == 0);
      wr_idx  = 4'd2;
      wr_data = 16'h0F0F;
      chk(1, S_ADDR, 16'hFFFF - 16'(i), "push_addr");
      chk(2, S_ADDR, (i < 2) ? 16'hFFFF - 16'(i) : 16'hFFFD, "push_addr");
      step();
    end
    push     = 1'b0;
    wr_en    = 1'b0;
    err_clr  = 1'b1;
    rd_a_idx = 4'd2;
    chk(1, S_SP, 16'hFFFC, "push3_sp");
    chk(1, S_CNT, 16'd3, "push3_cnt");
    chk(1, S_OVF, 16'd0, "push3_ovf");
    chk(1, S_A, 16'h0F0F, "wr_during_push");
    chk(2, S_SP, 16'hFFFD, "ovf_sp");
    chk(2, S_CNT, 16'd2, "ovf_cnt");
    chk(2, S_OVF, 16'd1, "ovf_set");
    step();
    err_clr = 1'b0;
    chk(2, S_OVF, 16'd0, "ovf_cleared");

    pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk(1, S_ADDR, 16'hFFFD + 16'(i), "pop_addr");
      chk(2, S_ADDR, (i == 0) ? 16'hFFFE :
                     (i == 1) ? 16'hFFFF : 16'h0000, "pop_addr");
      step();
    end
    pop = 1'b0;
    chk(1, S_SP, 16'hFFFF, "pop3_sp");
    chk(1, S_CNT, 16'd0, "pop3_cnt");
    chk(1, S_UNF, 16'd0, "pop3_unf");
    chk(2, S_SP, 16'hFFFF, "unf_sp");
    chk(2, S_UNF, 16'd1, "unf_set");

    pop = 1'b1;
    chk(1, S_ADDR, 16'h0000, "unf_addr");
    step();
    pop = 1'b0;
    chk(1, S_SP, 16'hFFFF, "unf_sp");
    chk(1, S_CNT, 16'd0, "unf_cnt");
    chk(1, S_UNF, 16'd1, "unf_set");

    push = 1'b1;
    step();
    push = 1'b0;
    chk(1, S_SP, 16'hFFFE, "push1_sp");
    step();

    push    = 1'b1;
    pop     = 1'b1;
    err_clr = 1'b1;
    chk(1, S_ADDR, 16'hFFFE, "ill_addr");
    step();
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    chk(1, S_SP, 16'hFFFE, "ill_sp");
    chk(1, S_CNT, 16'd1, "ill_cnt");
    chk(1, S_ERR, 16'd1, "err_beats_clr");
    chk(1, S_UNF, 16'd0, "unf_cleared");
    step();
    chk(1, S_ERR, 16'd1, "err_sticky");

    push     = 1'b1;
    wr_en    = 1'b1;
    wr_idx   = 4'd1;
    wr_data  = 16'hAAAA;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    push     = 1'b0;
    wr_en    = 1'b0;
    rd_a_idx = 4'd1;
    rd_b_idx = 4'd3;
    chk(1, S_A, 16'h0000, "rst_drops_wr");
    chk(1, S_B, 16'h0000, "rst_clears_r3");
    chk(1, S_SP, 16'hFFFF, "rst_drops_push");
    chk(1, S_CNT, 16'd0, "rst_cnt2");
    chk(1, S_ERR, 16'd0, "rst_err2");

    for (int i = 0; i < 5 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/asca_regfile.md
ASCA_REGFILE -- requirements
Module: asca_regfile

Interface
REQ-001 Parameter DATA_W, default 16, register and stack data/address width in bits.
REQ-002 Parameter REG_N, default 4, register index width; register count is 2**REG_N.
REQ-003 Parameter STACK_TOP, default 16'hFFFF, reset value of the stack pointer (first push address).
REQ-004 Parameter STACK_DEPTH, default 256, maximum number of stacked entries (1..2**DATA_W-1).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-006 rd_a_idx in REG_N, read port A index; rd_a_data out DATA_W, port A data.
REQ-007 rd_b_idx in REG_N, read port B index; rd_b_data out DATA_W, port B data.
REQ-008 wr_en in 1, write strobe; wr_idx in REG_N, write index; wr_data in DATA_W, write data.
REQ-009 push in 1, push request; pop in 1, pop request.
REQ-010 stk_addr out DATA_W, memory address for the current push/pop (combinational).
REQ-011 sp out DATA_W, registered stack pointer; stk_cnt out DATA_W, entries currently stacked.
REQ-012 stk_ovf out 1, stk_unf out 1, stk_err out 1, sticky error flags; err_clr in 1, clears all three.

Function
REQ-013 Reads SHALL be combinational: rd_x_data = reg[rd_x_idx] in the same cycle.
REQ-014 Writes SHALL commit on the rising clk edge when wr_en=1; visible to reads from the next cycle (plus bypass, REQ-027).
REQ-015 Stack SHALL be full-descending: push -> stk_addr=sp, sp<=sp-1, stk_cnt<=stk_cnt+1.
REQ-016 Pop -> stk_addr=sp+1 (modulo 2**DATA_W), sp<=sp+1, stk_cnt<=stk_cnt-1.
REQ-017 Idle (no push/pop) -> stk_addr = rd_b_data (port B as memory pointer), sp and stk_cnt hold.
REQ-018 Push with stk_cnt==STACK_DEPTH SHALL NOT move sp or stk_cnt; stk_ovf<=1; stk_addr still = sp.
REQ-019 Pop with stk_cnt==0 SHALL NOT move sp or stk_cnt; stk_unf<=1; stk_addr still = sp+1.
REQ-020 push and pop both high SHALL leave sp and stk_cnt unchanged, set stk_err<=1, stk_addr=sp.
REQ-021 sp arithmetic SHALL wrap modulo 2**DATA_W; wrap is not itself an error.
REQ-022 err_clr SHALL clear flags next edge; an error event in the same cycle as err_clr wins (flag set).
REQ-023 Flags SHALL stay set until err_clr or reset.
REQ-024 Register writes and stack operations in the same cycle SHALL proceed independently.

Reset
REQ-025 On reset edge: all registers 0, sp=STACK_TOP, stk_cnt=0, stk_ovf=stk_unf=stk_err=0; reset overrides wr_en, push, pop, err_clr in that cycle.
REQ-026 Reset asserted mid-sequence SHALL discard any in-flight push/pop and the coincident write.

Configuration
REQ-027 Macro ASCA_RF_BYPASS_EN defined: when wr_en=1 and wr_idx==rd_x_idx, rd_x_data SHALL return wr_data same cycle (both ports); undefined: rd_x_data returns stored value, write visible next cycle.

Structure
REQ-028 Shared package asca_pkg SHALL hold DATA_W/REG_N defaults, STACK_TOP/STACK_DEPTH defaults, and the stack-op encoding (IDLE, PUSH, POP, ILLEGAL).
REQ-029 One sub-module asca_stack_ctl SHALL hold sp, stk_cnt, flags and stk_addr; register array and bypass stay in asca_regfile.

Verification
REQ-030 Write R3=16'h1234 then read A=3,B=3 next cycle -> both 16'h1234; same-cycle read -> 16'h1234 with bypass, 16'h0000 without.
REQ-031 After reset, push x3 -> stk_addr FFFF,FFFE,FFFD; sp=FFFC, stk_cnt=3; pop x3 -> stk_addr FFFD,FFFE,FFFF; sp=FFFF.
REQ-032 STACK_DEPTH=2: push x3 -> third push sp stays FFFD, stk_ovf=1; err_clr -> stk_ovf=0 next cycle.
REQ-033 After reset pop -> stk_addr=0000, sp stays FFFF, stk_unf=1, stk_cnt=0.
REQ-034 push=pop=1 with sp=FFFE -> stk_addr=FFFE, sp unchanged, stk_err=1; same cycle with err_clr -> stk_err=1.
REQ-035 Push with wr_en R1=16'hAAAA, reset asserted same cycle -> R1=0, sp=FFFF, stk_cnt=0.
